hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the RV32IC in-order core; sits beside the ID stage and decoder.

---
 rtl/hazard_ctrl_pkg.sv | 33 +++
 rtl/hazard_ctrl_scoreboard.sv | 61 ++++++
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_hazard_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control types for the RV32IC hazard/redirect sequencer.
package hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      BR_WAIT  = 2'd1,
      REDIRECT = 2'd2
   } ctrl_state_e;

   // One in-flight destination tracked behind ID.
   typedef struct packed {
      logic       v;
      logic [4:0] rd;
      logic       load;
   } sb_entry_t;

   // EX-stage control fields forced when a bubble is injected.
   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      logic [4:0] rd;
   } ex_ctrl_t;

   localparam logic [4:0] REG_X0   = 5'd0;
   localparam sb_entry_t  SB_EMPTY = '{v: 1'b0, rd: REG_X0, load: 1'b0};
   localparam ex_ctrl_t   EX_NOP   = '{reg_write: 1'b0, mem_write: 1'b0, rd: REG_X0};

   // x0 is hardwired, so a read of x0 can never depend on an older write.
   function automatic logic src_match(logic use_rs, logic [4:0] rs, sb_entry_t e);
      return use_rs && (rs != REG_X0) && e.v && (rs == e.rd);
   endfunction

endpackage

// File: rtl/hazard_ctrl_scoreboard.sv
// In-flight destination pipe (EX, MEM, WB) and source-match hazard detection.
module hazard_scoreboard
   import hazard_ctrl_pkg::*;
#(
   parameter int DEPTH  = 3,
   parameter bit FWD_EN = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       id_valid_i,
   input  logic [4:0] id_rs1_i,
   input  logic [4:0] id_rs2_i,
   input  logic       id_use_rs1_i,
   input  logic       id_use_rs2_i,
   input  logic [4:0] id_rd_i,
   input  logic       id_regwrite_i,
   input  logic       id_is_load_i,
   input  logic       issue_i,
   output logic       hz_o
);

   sb_entry_t sb_q [DEPTH];
   sb_entry_t entry0_d;

   // New EX entry: only a real, issued, non-x0 write is tracked; bubbles enter as invalid.
   always_comb begin
      entry0_d      = SB_EMPTY;
      entry0_d.v    = issue_i && id_regwrite_i && (id_rd_i != REG_X0);
      entry0_d.rd   = id_rd_i;
      entry0_d.load = id_is_load_i;
   end

   // Shift every cycle; downstream stages never back-pressure.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) sb_q[i] <= SB_EMPTY;
      end else begin
         sb_q[0] <= entry0_d;
         for (int i = 1; i < DEPTH; i++) sb_q[i] <= sb_q[i-1];
      end
   end

   // With forwarding only a load still in EX blocks; without it, anything short of WB does.
   always_comb begin
      hz_o = 1'b0;
      if (FWD_EN) begin
         if (sb_q[0].load &&
             (src_match(id_use_rs1_i, id_rs1_i, sb_q[0]) ||
              src_match(id_use_rs2_i, id_rs2_i, sb_q[0])))
            hz_o = 1'b1;
      end else begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            if (src_match(id_use_rs1_i, id_rs1_i, sb_q[i]) ||
                src_match(id_use_rs2_i, id_rs2_i, sb_q[i]))
               hz_o = 1'b1;
         end
      end
      hz_o = hz_o & id_valid_i;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: stall/bubble/flush generation and PC redirect for JAL, JALR, branches.
//
//  state    | meaning
//  RUN      | normal issue; JAL redirects from ID, branch/JALR issue and wait
//  BR_WAIT  | branch/JALR in EX; fetch held until EX resolves it
//  REDIRECT | one bubble to discard the fetch in flight after a taken redirect
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int DEPTH  = 3,
   parameter bit FWD_EN = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            id_valid,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic            id_use_rs1,
   input  logic            id_use_rs2,
   input  logic [4:0]      id_rd,
   input  logic            id_regwrite,
   input  logic            id_is_load,
   input  logic            id_is_jal,
   input  logic            id_is_jalr,
   input  logic            id_is_branch,
   input  logic [XLEN-1:0] id_target,
   input  logic            ex_resolve,
   input  logic            ex_taken,
   input  logic [XLEN-1:0] ex_target,
   output logic            stall,
   output logic            issue_nop,
   output logic            flush_id,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc
);

   ctrl_state_e     state_q, state_d;
   logic [XLEN-1:0] redirect_pc_q, target_c;
   logic            hz, run_issue;
   logic            stall_c, nop_c, flush_c, redir_c;

   hazard_scoreboard #(.DEPTH(DEPTH), .FWD_EN(FWD_EN)) u_sb (
      .clk           (clk),
      .reset         (reset),
      .id_valid_i    (id_valid),
      .id_rs1_i      (id_rs1),
      .id_rs2_i      (id_rs2),
      .id_use_rs1_i  (id_use_rs1),
      .id_use_rs2_i  (id_use_rs2),
      .id_rd_i       (id_rd),
      .id_regwrite_i (id_regwrite),
      .id_is_load_i  (id_is_load),
      .issue_i       (id_valid & ~issue_nop),
      .hz_o          (hz)
   );

   // State register and last redirect target.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= RUN;
         redirect_pc_q <= '0;
      end else begin
         state_q <= state_d;
         if (redirect_valid) redirect_pc_q <= target_c;
      end
   end

   // Next state and control outputs; a not-taken resolve hands ID straight back to RUN logic.
   always_comb begin
      state_d   = state_q;
      stall_c   = 1'b0;
      nop_c     = 1'b0;
      flush_c   = 1'b0;
      redir_c   = 1'b0;
      target_c  = redirect_pc_q;
      run_issue = 1'b0;
      case (state_q)
         RUN: run_issue = 1'b1;
         BR_WAIT: begin
            if (ex_resolve && ex_taken) begin
               redir_c  = 1'b1;
               target_c = ex_target;
               flush_c  = 1'b1;
               nop_c    = 1'b1;
               state_d  = REDIRECT;
            end else if (ex_resolve) begin
               run_issue = 1'b1;
            end else begin
               stall_c = 1'b1;
               nop_c   = 1'b1;
            end
         end
         REDIRECT: begin
            nop_c   = 1'b1;
            state_d = RUN;
         end
         default: state_d = RUN;
      endcase
      if (run_issue) begin
         state_d = RUN;
         if (hz) begin
            stall_c = 1'b1;
            nop_c   = 1'b1;
         end else if (id_valid && id_is_jal) begin
            redir_c  = 1'b1;
            target_c = id_target;
            flush_c  = 1'b1;
         end else if (id_valid && (id_is_branch || id_is_jalr)) begin
            state_d = BR_WAIT;
         end
      end
   end

   // Reset forces every control output low immediately, independent of ID inputs.
   assign stall          = stall_c & reset;
   assign issue_nop      = nop_c & reset;
   assign flush_id       = flush_c & reset;
   assign redirect_valid = redir_c & reset;
   assign redirect_pc    = redirect_valid ? target_c : redirect_pc_q;

   // An outcome arriving with nothing outstanding means EX and ID disagree about the pipe.
   a_resolve_in_run: assert property (@(posedge clk) disable iff (!reset)
      !(state_q == RUN && ex_resolve));

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_is_load;
   logic        id_is_jal, id_is_jalr, id_is_branch;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [31:0] id_target, ex_target;
   logic        ex_resolve, ex_taken;

   logic        f_stall, f_nop, f_flush, f_rv;
   logic [31:0] f_pc;
   logic        n_stall, n_nop, n_flush, n_rv;
   logic [31:0] n_pc;

   int n_asserts = 0;
   int n_fail    = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.XLEN(32), .DEPTH(3), .FWD_EN(1'b1)) u_fwd (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
      .id_regwrite(id_regwrite), .id_is_load(id_is_load), .id_is_jal(id_is_jal),
      .id_is_jalr(id_is_jalr), .id_is_branch(id_is_branch), .id_target(id_target),
      .ex_resolve(ex_resolve), .ex_taken(ex_taken), .ex_target(ex_target),
      .stall(f_stall), .issue_nop(f_nop), .flush_id(f_flush),
      .redirect_valid(f_rv), .redirect_pc(f_pc));

   hazard_ctrl #(.XLEN(32), .DEPTH(3), .FWD_EN(1'b0)) u_nofwd (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
      .id_regwrite(id_regwrite), .id_is_load(id_is_load), .id_is_jal(id_is_jal),
      .id_is_jalr(id_is_jalr), .id_is_branch(id_is_branch), .id_target(id_target),
      .ex_resolve(ex_resolve), .ex_taken(ex_taken), .ex_target(ex_target),
      .stall(n_stall), .issue_nop(n_nop), .flush_id(n_flush),
      .redirect_valid(n_rv), .redirect_pc(n_pc));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic clr_id();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      id_rd = 0; id_regwrite = 0; id_is_load = 0; id_is_jal = 0; id_is_jalr = 0;
      id_is_branch = 0; id_target = 0;
   endtask

   task automatic set_alu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic load);
      clr_id();
      id_valid = 1; id_rd = rd; id_regwrite = 1; id_is_load = load;
      id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
   endtask

   task automatic set_beq(input logic [4:0] rs1, input logic [4:0] rs2);
      clr_id();
      id_valid = 1; id_is_branch = 1;
      id_rs1 = rs1; id_use_rs1 = 1; id_rs2 = rs2; id_use_rs2 = 1;
   endtask

   task automatic drain();
      clr_id();
      repeat (3) next_cycle();
   endtask

   initial begin
      reset = 0; ex_resolve = 0; ex_taken = 0; ex_target = 0;
      clr_id();
      id_valid = 1; id_is_jal = 1; id_target = 32'h200;
      repeat (2) settle();
      check("rst_stall",  {31'd0, f_stall}, 32'd0);
      check("rst_nop",    {31'd0, f_nop},   32'd0);
      check("rst_flush",  {31'd0, f_flush}, 32'd0);
      check("rst_rv",     {31'd0, f_rv},    32'd0);
      check("rst_pc",     f_pc,             32'd0);
      check("rst_rv_nf",  {31'd0, n_rv},    32'd0);
      clr_id();
      next_cycle();
      reset = 1;

      // LW x5 then ADD x6,x5,x7
      set_alu(5'd5, 5'd1, 1, 5'd0, 0, 1);
      settle();
      check("lw_stall_f", {31'd0, f_stall}, 32'd0);
      check("lw_stall_n", {31'd0, n_stall}, 32'd0);
      next_cycle();
      set_alu(5'd6, 5'd5, 1, 5'd7, 1, 0);
      settle();
      check("lu1_stall_f", {31'd0, f_stall}, 32'd1);
      check("lu1_nop_f",   {31'd0, f_nop},   32'd1);
      check("lu1_stall_n", {31'd0, n_stall}, 32'd1);
      check("lu1_nop_n",   {31'd0, n_nop},   32'd1);
      next_cycle();
      settle();
      check("lu2_stall_f", {31'd0, f_stall}, 32'd0);
      check("lu2_nop_f",   {31'd0, f_nop},   32'd0);
      check("lu2_stall_n", {31'd0, n_stall}, 32'd1);
      next_cycle();
      settle();
      check("lu3_stall_f", {31'd0, f_stall}, 32'd0);
      check("lu3_stall_n", {31'd0, n_stall}, 32'd0);
      drain();

      // load-use on rs2 only
      set_alu(5'd9, 5'd1, 1, 5'd0, 0, 1);
      next_cycle();
      set_alu(5'd10, 5'd3, 1, 5'd9, 1, 0);
      settle();
      check("rs2_stall_f", {31'd0, f_stall}, 32'd1);
      check("rs2_stall_n", {31'd0, n_stall}, 32'd1);
      drain();

      // LW x0 then ADDI x1,x0
      set_alu(5'd0, 5'd2, 1, 5'd0, 0, 1);
      next_cycle();
      set_alu(5'd1, 5'd0, 1, 5'd0, 0, 0);
      settle();
      check("x0_stall_f", {31'd0, f_stall}, 32'd0);
      check("x0_stall_n", {31'd0, n_stall}, 32'd0);
      drain();

      // ALU producer: forwarded with FWD_EN=1, stalls without; unused source ignored
      set_alu(5'd8, 5'd2, 1, 5'd0, 0, 0);
      next_cycle();
      set_alu(5'd11, 5'd3, 1, 5'd8, 0, 0);
      settle();
      check("unused_stall_n", {31'd0, n_stall}, 32'd0);
      set_alu(5'd11, 5'd8, 1, 5'd3, 0, 0);
      settle();
      check("alu_stall_f", {31'd0, f_stall}, 32'd0);
      check("alu_stall_n", {31'd0, n_stall}, 32'd1);
      drain();

      // JAL
      clr_id();
      id_valid = 1; id_is_jal = 1; id_rd = 5'd1; id_regwrite = 1; id_target = 32'h100;
      settle();
      check("jal_rv",    {31'd0, f_rv},    32'd1);
      check("jal_pc",    f_pc,             32'h100);
      check("jal_flush", {31'd0, f_flush}, 32'd1);
      check("jal_stall", {31'd0, f_stall}, 32'd0);
      next_cycle();
      clr_id();
      settle();
      check("jal_rv_off", {31'd0, f_rv},    32'd0);
      check("jal_pc_hold", f_pc,            32'h100);
      check("jal_flush_off", {31'd0, f_flush}, 32'd0);
      drain();

      // BEQ taken
      set_beq(5'd2, 5'd3);
      settle();
      check("beq_issue_stall", {31'd0, f_stall}, 32'd0);
      check("beq_issue_nop",   {31'd0, f_nop},   32'd0);
      next_cycle();
      clr_id();
      settle();
      check("bw1_stall", {31'd0, f_stall}, 32'd1);
      check("bw1_nop",   {31'd0, f_nop},   32'd1);
      check("bw1_rv",    {31'd0, f_rv},    32'd0);
      next_cycle();
      settle();
      check("bw2_stall", {31'd0, n_stall}, 32'd1);
      next_cycle();
      ex_resolve = 1; ex_taken = 1; ex_target = 32'h40;
      settle();
      check("tk_stall", {31'd0, f_stall}, 32'd0);
      check("tk_rv",    {31'd0, f_rv},    32'd1);
      check("tk_pc",    f_pc,             32'h40);
      check("tk_flush", {31'd0, f_flush}, 32'd1);
      check("tk_nop",   {31'd0, f_nop},   32'd1);
      next_cycle();
      ex_resolve = 0; ex_taken = 0; ex_target = 0;
      settle();
      check("rd_nop",   {31'd0, f_nop},   32'd1);
      check("rd_stall", {31'd0, f_stall}, 32'd0);
      check("rd_rv",    {31'd0, f_rv},    32'd0);
      check("rd_pc",    f_pc,             32'h40);
      next_cycle();
      settle();
      check("run_nop",   {31'd0, f_nop},   32'd0);
      check("run_stall", {31'd0, f_stall}, 32'd0);

      // BEQ not taken
      set_beq(5'd2, 5'd3);
      next_cycle();
      clr_id();
      settle();
      check("nt_w1_stall", {31'd0, f_stall}, 32'd1);
      next_cycle();
      settle();
      check("nt_w2_stall", {31'd0, f_stall}, 32'd1);
      next_cycle();
      ex_resolve = 1; ex_taken = 0; ex_target = 32'h80;
      settle();
      check("nt_stall", {31'd0, f_stall}, 32'd0);
      check("nt_flush", {31'd0, f_flush}, 32'd0);
      check("nt_rv",    {31'd0, f_rv},    32'd0);
      check("nt_pc",    f_pc,             32'h40);
      next_cycle();
      ex_resolve = 0; ex_target = 0;
      settle();
      check("nt_run_stall", {31'd0, f_stall}, 32'd0);
      check("nt_run_nop",   {31'd0, f_nop},   32'd0);

      // reset during BR_WAIT
      set_beq(5'd2, 5'd3);
      next_cycle();
      clr_id();
      settle();
      check("rbw_stall_pre", {31'd0, f_stall}, 32'd1);
      #2 reset = 0;
      #1;
      check("rbw_stall", {31'd0, f_stall}, 32'd0);
      check("rbw_nop",   {31'd0, f_nop},   32'd0);
      check("rbw_pc",    f_pc,             32'd0);
      check("rbw_stall_n", {31'd0, n_stall}, 32'd0);
      next_cycle();
      reset = 1;
      clr_id();
      id_valid = 1; id_is_jal = 1; id_target = 32'h300;
      settle();
      check("post_rst_rv",    {31'd0, f_rv},    32'd1);
      check("post_rst_stall", {31'd0, f_stall}, 32'd0);
      check("post_rst_pc",    f_pc,             32'h300);
      next_cycle();
      clr_id();
      next_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
